boot_loader: RTL and testbench

Upstream boot stage for the multicycle CPU. Receives a framed byte stream over a valid/ready byte interface and assembles the bytes into 32-bit big-endian words. Writes those words into main memory from a fixed base address, then releases the CPU from reset. The CPU stays held in reset (`cpu_reset`=1) until a frame passes its checksum, so program memory is always fully populated at address 0 before the first fetch.

---
 rtl/boot_loader_pkg.sv | 25 ++
 rtl/boot_loader_if.sv | 22 ++
 rtl/boot_loader.sv | 157 +++++++++++++++
 tb/tb_boot_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: frame sync byte,
// count width, FSM state encoding and the word address helper.
package boot_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         CNT_W     = 16;

   typedef enum logic [2:0] {
      IDLE,
      CNT_HI,
      CNT_LO,
      DATA,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } boot_state_t;

   // Byte address of word idx: base + (idx << 2), wrapping modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0]      base,
                                             input logic [CNT_W-1:0] idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and memory write port of the boot loader.
// master = stream source / memory side, slave = the loader itself.
interface boot_loader_if;

   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, mem_wr, mem_addr, mem_wdata
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, mem_wr, mem_addr, mem_wdata
   );

endinterface

// File: rtl/boot_loader.sv
// Boot loader: parses a framed byte stream (SYNC, CNT_HI, CNT_LO,
// CNT x 4 data bytes, CHK), writes big-endian words to memory starting at
// BASE_ADDR and releases the CPU from reset once the XOR checksum matches.
module boot_loader
   import boot_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic         clk,
   input  logic         reset,
   boot_loader_if.slave bus,
   output logic         cpu_reset,
   output logic         done,
   output logic         error
);

   boot_state_t      state;
   logic             armed;
   logic [7:0]       cnt_hi;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] word_idx;
   logic [1:0]       byte_idx;
   logic [23:0]      shift_reg;
   logic [7:0]       chk;
   logic             mem_wr_q;
   logic [31:0]      mem_addr_q;
   logic [31:0]      mem_wdata_q;
   logic             rx_ready_c;

   logic             accept;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] idx_next;

   assign accept   = bus.rx_valid && rx_ready_c;
   assign cnt_next = {cnt_hi, bus.rx_data};
   assign idx_next = word_idx + 16'd1;

   assign bus.rx_ready  = rx_ready_c;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   // Ready is decoded from state, gated until the first edge after reset.
   // NOTE: 'armed' is cleared by reset and set on the first clock, so ready
   // stays low during reset and rises one edge after it is released.
   always_comb begin
      rx_ready_c = 1'b0;
      if (armed) begin
         unique case (state)
            IDLE, CNT_HI, CNT_LO, DATA, CHECK: rx_ready_c = 1'b1;
            default:                           rx_ready_c = 1'b0;
         endcase
      end
   end

   // Frame FSM with the shifter, checksum, word counter and registered outputs.
   // NOTE: every state element is a plain flop with an async reset; there is
   // no storage array here, so nothing escapes the reset. Non-blocking
   // assignments keep all flops updating from the same pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         armed       <= 1'b0;
         cnt_hi      <= '0;
         cnt         <= '0;
         word_idx    <= '0;
         byte_idx    <= '0;
         shift_reg   <= '0;
         chk         <= '0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_reset   <= 1'b1;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         armed    <= 1'b1;
         mem_wr_q <= 1'b0;

         unique case (state)
            // Hunt for the sync byte; anything else is dropped.
            IDLE: begin
               if (accept && bus.rx_data == SYNC_BYTE) begin
                  state <= CNT_HI;
               end
            end

            CNT_HI: begin
               if (accept) begin
                  cnt_hi <= bus.rx_data;
                  state  <= CNT_LO;
               end
            end

            // Full count known here; start a fresh word/checksum context.
            CNT_LO: begin
               if (accept) begin
                  cnt       <= cnt_next;
                  word_idx  <= '0;
                  byte_idx  <= '0;
                  shift_reg <= '0;
                  chk       <= '0;
                  if ({16'd0, cnt_next} > MAX_WORDS) begin
                     state <= ERROR;
                     error <= 1'b1;
                  end else if (cnt_next == '0) begin
                     state <= CHECK;
                  end else begin
                     state <= DATA;
                  end
               end
            end

            // Big-endian assembly: the first byte ends up in bits [31:24].
            DATA: begin
               if (accept) begin
                  shift_reg <= {shift_reg[15:0], bus.rx_data};
                  chk       <= chk ^ bus.rx_data;
                  byte_idx  <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     mem_wr_q    <= 1'b1;
                     mem_addr_q  <= word_addr(BASE_ADDR, word_idx);
                     mem_wdata_q <= {shift_reg, bus.rx_data};
                     state       <= WRITE;
                  end
               end
            end

            // Strobe cycle; input is stalled so each word costs one bubble.
            WRITE: begin
               word_idx <= idx_next;
               state    <= (idx_next < cnt) ? DATA : CHECK;
            end

            CHECK: begin
               if (accept) begin
                  if (bus.rx_data == chk) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
            end

            // Terminal states: only reset leaves them.
            DONE:    state <= DONE;
            ERROR:   state <= ERROR;
            default: state <= ERROR;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a table of framed byte streams with
// expected writes and final status, plus hand sequences for reset behaviour,
// terminal-state byte rejection and the MAX_WORDS boundary with input stalls.
`timescale 1ns/1ps
module tb_boot_loader;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic cpu_reset;
   logic done;
   logic error;

   boot_loader_if bus();

   boot_loader #(
      .BASE_ADDR (32'h0000_0000),
      .MAX_WORDS (256)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      string       name;
      int          start;
      int          len;
      int          nw;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   wr_t         exp_q[$];
   logic [7:0]  stream[$];
   vec_t        vecs[7];
   int          tests     = 0;
   int          fails     = 0;
   int          ready_low = 0;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected write
   // and must fall in a cycle where input is stalled.
   always @(negedge clk) begin
      if (bus.mem_wr === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {1'b0, bus.mem_addr, bus.mem_wdata}, 65'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write", {bus.rx_ready, bus.mem_addr, bus.mem_wdata}, {1'b0, e.addr, e.data});
         end
      end
   end

   // Called at a negedge; returns at the negedge after the byte was taken.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (bus.rx_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
         ready_low++;
      end
      check("ready_wait", {64'd0, bus.rx_ready}, 65'd1);
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic add_vec(input int idx, input string name, input int s, input int nw,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input bit d, input bit e);
      vecs[idx] = '{name, s, stream.size() - s, nw, w0, w1, d, e};
   endtask

   initial begin
      int          s;
      logic [7:0]  sum;
      logic [31:0] w;
      int          gap;

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      // ---------------- vector table ----------------
      s = stream.size();
      stream = {stream, 8'h00, 8'h12, 8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      add_vec(0, "single_word", s, 1, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
      s = stream.size();
      stream = {stream, 8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
      add_vec(1, "two_words", s, 2, 32'h1122_3344, 32'h5566_7788, 1'b1, 1'b0);
      s = stream.size();
      stream = {stream, 8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h08};
      add_vec(2, "two_words_badchk", s, 2, 32'h1122_3344, 32'h5566_7788, 1'b0, 1'b1);
      s = stream.size();
      stream = {stream, 8'hA5, 8'h00, 8'h00, 8'h00};
      add_vec(3, "zero_count", s, 0, 32'h0, 32'h0, 1'b1, 1'b0);
      s = stream.size();
      stream = {stream, 8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
      add_vec(4, "bad_chk", s, 1, 32'h0102_0304, 32'h0, 1'b0, 1'b1);
      s = stream.size();
      stream = {stream, 8'hA5, 8'h01, 8'h01};
      add_vec(5, "too_many", s, 0, 32'h0, 32'h0, 1'b0, 1'b1);
      s = stream.size();
      stream = {stream, 8'hA5, 8'h00, 8'h00, 8'h5A};
      add_vec(6, "zero_count_badchk", s, 0, 32'h0, 32'h0, 1'b0, 1'b1);

      // ---------------- reset values and ready rise ----------------
      @(negedge clk);
      check("reset_ctrl", {60'd0, cpu_reset, done, error, bus.rx_ready, bus.mem_wr}, {60'd0, 5'b10000});
      check("reset_mem", {1'b0, bus.mem_addr, bus.mem_wdata}, 65'd0);
      reset = 1'b1;
      #1;
      check("ready_after_release", {64'd0, bus.rx_ready}, 65'd0);
      @(negedge clk);
      check("ready_first_edge", {64'd0, bus.rx_ready}, 65'd1);

      // ---------------- table-driven frames ----------------
      for (int v = 0; v < 7; v++) begin
         do_reset();
         if (vecs[v].nw > 0) exp_q.push_back('{32'h0000_0000, vecs[v].w0});
         if (vecs[v].nw > 1) exp_q.push_back('{32'h0000_0004, vecs[v].w1});
         ready_low = 0;
         for (int k = 0; k < vecs[v].len; k++) begin
            if (k == vecs[v].len - 1)
               check({vecs[v].name, "_before_last"}, {62'd0, done, error, cpu_reset}, {62'd0, 3'b001});
            send_byte(stream[vecs[v].start + k]);
         end
         check({vecs[v].name, "_status"}, {62'd0, done, error, cpu_reset},
               {62'd0, vecs[v].exp_done, vecs[v].exp_err, ~vecs[v].exp_done});
         check({vecs[v].name, "_stall_cycles"}, 65'(ready_low), 65'(vecs[v].nw));
         @(negedge clk);
         check({vecs[v].name, "_sb_empty"}, 65'(exp_q.size()), 65'd0);
      end

      // ---------------- ERROR is terminal: later bytes ignored ----------------
      bus.rx_valid = 1'b1;
      foreach (stream[k]) begin
         if (k < 8) begin
            bus.rx_data = stream[k + 2];
            @(negedge clk);
         end
      end
      bus.rx_valid = 1'b0;
      check("error_terminal", {61'd0, done, error, cpu_reset, bus.rx_ready}, {61'd0, 4'b0110});

      // ---------------- reset mid-frame, then a clean frame ----------------
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h11);
      send_byte(8'h22);
      #2 reset = 1'b0;
      #1;
      check("midframe_reset", {61'd0, cpu_reset, bus.mem_wr, bus.rx_ready, done}, {61'd0, 4'b1000});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_q.push_back('{32'h0000_0000, 32'hCAFE_BABE});
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hCA);
      send_byte(8'hFE);
      send_byte(8'hBA);
      send_byte(8'hBE);
      send_byte(8'h30);
      check("after_reset_done", {63'd0, done, cpu_reset}, {63'd0, 2'b10});
      @(negedge clk);
      check("after_reset_sb_empty", 65'(exp_q.size()), 65'd0);
      check("mem_hold", {1'b0, bus.mem_addr, bus.mem_wdata}, {1'b0, 32'h0, 32'hCAFE_BABE});

      // ---------------- reset after DONE reasserts cpu_reset at once ----------------
      #2 reset = 1'b0;
      #1;
      check("reset_after_done", {62'd0, cpu_reset, done, error}, {62'd0, 3'b100});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // ---------------- CNT = MAX_WORDS with random input stalls ----------------
      do_reset();
      sum = 8'h00;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         w = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'h3C};
         exp_q.push_back('{32'(i * 4), w});
         for (int b = 3; b >= 0; b--) begin
            sum = sum ^ w[b*8 +: 8];
            send_byte(w[b*8 +: 8]);
            gap = $urandom_range(0, 1);
            repeat (gap) @(negedge clk);
         end
      end
      check("max_words_before_chk", {63'd0, done, error}, {63'd0, 2'b00});
      send_byte(sum);
      check("max_words_status", {62'd0, done, error, cpu_reset}, {62'd0, 3'b100});
      @(negedge clk);
      check("max_words_sb_empty", 65'(exp_q.size()), 65'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
